spu_sm_sched: RTL and testbench
===============================

# spu_sm_sched

Job scheduler in front of the SPU softmax engine. Accepts softmax job descriptors over a valid/ready command port and buffers them in a small FIFO. For each job it drives stable configuration to the engine, issues a one-cycle start pulse, and waits for the engine's end pulse under a programmable timeout. It reports one completion per job with tag and error code, so the host can queue back-to-back softmax tiles without polling.

## Interface
Parameters:
- ADDR_WIDTH, 12, width of all dimension/address/alignment fields
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TAG_WIDTH, 4, job tag width
- TIMEOUT_W, 16, timeout counter width

Ports:
- core_clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  FIFO not full
- cmd_matrix_y / cmd_matrix_x  in  ADDR_WIDTH each  rows / row length
- cmd_im_base / cmd_om_base  in  ADDR_WIDTH each  input / output base address
- cmd_ifm_align / cmd_ofm_align  in  ADDR_WIDTH each  row strides
- cmd_shift_input  in  4  input shift
- cmd_exp_shift_output  in  5  exp output shift
- cmd_shift_output  in  4  final output shift
- cmd_tag  in  TAG_WIDTH  job tag
- timeout_limit  in  TIMEOUT_W  max RUN cycles; 0 disables
- abort  in  1  pulse: flush queued jobs
- sm_start  out  1  one-cycle engine start
- sm_end  in  1  one-cycle engine completion
- spu_matrix_y, spu_matrix_x, im_base_addr, om_base_addr, ifm_addr_align, ofm_addr_align  out  ADDR_WIDTH each  registered config to the engine
- sm_shift_input (4), sm_exp_shift_output (5), sm_shift_output (4)  out  registered config to the engine
- done_valid  out  1  one-cycle completion pulse
- done_tag  out  TAG_WIDTH  tag of the completed job
- done_err  out  2  0 ok, 1 illegal descriptor, 2 timeout
- busy  out  1  state ≠ IDLE or FIFO non-empty
- q_count  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset: FIFO empty, state IDLE, all outputs 0. cmd_ready is forced 0 while rst is high and is 1 after rst deasserts.
- Push: cmd_valid & cmd_ready. cmd_ready = (q_count < DEPTH). Simultaneous push and pop is allowed; q_count is unchanged in that cycle.
- FSM states: IDLE, START, RUN, DONE, DRAIN.
- IDLE, FIFO non-empty: pop the head into the config and tag registers.
  - Descriptor is illegal if matrix_y == 0, matrix_x == 0, or matrix_x[1:0] ≠ 0. An illegal descriptor goes to DONE with err = 1.
  - Otherwise go to START.
- START: sm_start = 1 for exactly one cycle, then RUN. Clear the timeout counter.
- RUN: the counter increments each cycle.
  - sm_end → DONE with err = 0.
  - Else if timeout_limit ≠ 0 and counter == timeout_limit−1 → DONE with err = 2.
  - sm_end in the timeout cycle wins (err = 0).
- DONE: done_valid = 1 for one cycle with done_tag and done_err.
  - After err = 2, go to DRAIN.
  - Otherwise go to IDLE.
- DRAIN: wait for the late sm_end, then IDLE. No done pulse is reported for it.
- Config outputs hold their value from the pop until the next pop. They never change during START, RUN or DRAIN.
- sm_end received in IDLE, START or DONE is ignored.
- abort: empties the FIFO in the same edge; flushed jobs get no done. A push in the abort cycle is discarded.
  - In DRAIN, abort forces IDLE.
  - In RUN, the current job continues normally.
- Mid-operation reset returns to the reset state immediately. The engine must be reset alongside the scheduler.

## Timing
- Push accepted in cycle 0 into an empty FIFO while IDLE:
  - cycle 1: pop;
  - cycle 2: sm_start = 1 with config valid;
  - cycle 3: first RUN cycle.
- sm_end in cycle n → done_valid in cycle n+1 → IDLE in n+2. The next queued job's sm_start comes at n+3.
- Illegal descriptor popped in cycle k → done_valid, err = 1, in cycle k+1. No sm_start is issued.
- Timeout with limit L: the DONE pulse comes L+1 cycles after sm_start.
- q_count updates the cycle after the push or pop edge.

## Structure
- Shared package spu_pkg holds:
  - FSM state encoding (3 bits);
  - error codes SM_ERR_OK/ILLEGAL/TIMEOUT;
  - descriptor field widths and the packed descriptor layout (sum of field widths + TAG_WIDTH).
- One sub-module, spu_cmd_fifo: synchronous FIFO with flush, count, full/empty, parameterized width/depth. The scheduler FSM, config registers and timeout counter live in spu_sm_sched.

## Test plan
- Single legal job (y=4, x=16, tag=3): sm_start in cycle 2 with config echoing the descriptor. Drive sm_end 50 cycles later → one done_valid, tag=3, err=0.
- Push 5 jobs back-to-back with DEPTH=4: cmd_ready drops after the 4th push and rises after the first pop. Completions come in order, tags 0..4, each sm_start 3 cycles after the prior sm_end.
- Descriptor with x=18: no sm_start, done_valid one cycle after the pop with err=1. The next job then starts normally.
- timeout_limit=10, no sm_end: done err=2 at sm_start+11, then DRAIN. sm_end 20 cycles later → IDLE with no extra done. Repeat with sm_end in the timeout cycle → err=0.
- Queue 3 jobs, pulse abort during RUN of the first: q_count=0 next cycle, first job completes, no further sm_start.
- Assert rst mid-RUN: all outputs 0 and q_count=0 while rst is high; after release a new job starts cleanly.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared definitions for the SPU softmax job scheduler: FSM encoding, error codes
// and the packed command-descriptor layout.
package spu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } sm_state_e;

  localparam logic [1:0] SM_ERR_OK      = 2'd0;
  localparam logic [1:0] SM_ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] SM_ERR_TIMEOUT = 2'd2;

  localparam int SHIFT_IN_W      = 4;
  localparam int EXP_SHIFT_W     = 5;
  localparam int SHIFT_OUT_W     = 4;
  localparam int NUM_ADDR_FIELDS = 6;

  // Descriptor packing, LSB first: matrix_y, matrix_x, im_base, om_base,
  // ifm_align, ofm_align, shift_input, exp_shift_output, shift_output, tag.
  function automatic int desc_width(input int addr_w, input int tag_w);
    return NUM_ADDR_FIELDS * addr_w + SHIFT_IN_W + EXP_SHIFT_W + SHIFT_OUT_W + tag_w;
  endfunction

endpackage

// File: rtl/spu_cmd_fifo.sv
// Synchronous FIFO with flush and occupancy count. Flush wins over a same-cycle
// push or pop; head data is presented combinationally on rdata.
module spu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spu_sm_sched.sv
// Softmax job scheduler: queues descriptors, launches the engine one job at a
// time with a start pulse and reports one completion per job (tag + error).
module spu_sm_sched
  import spu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                    core_clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_matrix_y,
  input  logic [ADDR_WIDTH-1:0]   cmd_matrix_x,
  input  logic [ADDR_WIDTH-1:0]   cmd_im_base,
  input  logic [ADDR_WIDTH-1:0]   cmd_om_base,
  input  logic [ADDR_WIDTH-1:0]   cmd_ifm_align,
  input  logic [ADDR_WIDTH-1:0]   cmd_ofm_align,
  input  logic [3:0]              cmd_shift_input,
  input  logic [4:0]              cmd_exp_shift_output,
  input  logic [3:0]              cmd_shift_output,
  input  logic [TAG_WIDTH-1:0]    cmd_tag,
  input  logic [TIMEOUT_W-1:0]    timeout_limit,
  input  logic                    abort,
  output logic                    sm_start,
  input  logic                    sm_end,
  output logic [ADDR_WIDTH-1:0]   spu_matrix_y,
  output logic [ADDR_WIDTH-1:0]   spu_matrix_x,
  output logic [ADDR_WIDTH-1:0]   im_base_addr,
  output logic [ADDR_WIDTH-1:0]   om_base_addr,
  output logic [ADDR_WIDTH-1:0]   ifm_addr_align,
  output logic [ADDR_WIDTH-1:0]   ofm_addr_align,
  output logic [3:0]              sm_shift_input,
  output logic [4:0]              sm_exp_shift_output,
  output logic [3:0]              sm_shift_output,
  output logic                    done_valid,
  output logic [TAG_WIDTH-1:0]    done_tag,
  output logic [1:0]              done_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int DW = desc_width(ADDR_WIDTH, TAG_WIDTH);

  logic [DW-1:0]         fifo_wdata;
  logic [DW-1:0]         fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;

  logic [ADDR_WIDTH-1:0] h_y, h_x, h_ib, h_ob, h_ia, h_oa;
  logic [3:0]            h_si;
  logic [4:0]            h_es;
  logic [3:0]            h_so;
  logic [TAG_WIDTH-1:0]  h_tag;
  logic                  head_illegal;
  logic                  timeout_hit;

  sm_state_e             state;
  logic [TIMEOUT_W-1:0]  run_cnt;
  logic [TAG_WIDTH-1:0]  job_tag;

  assign fifo_wdata = {cmd_tag, cmd_shift_output, cmd_exp_shift_output, cmd_shift_input,
                       cmd_ofm_align, cmd_ifm_align, cmd_om_base, cmd_im_base,
                       cmd_matrix_x, cmd_matrix_y};
  assign {h_tag, h_so, h_es, h_si, h_oa, h_ia, h_ob, h_ib, h_x, h_y} = fifo_rdata;

  // Reset holds cmd_ready low even though the FIFO is empty at that point.
  assign cmd_ready    = !rst && !fifo_full;
  assign fifo_push    = cmd_valid && cmd_ready && !abort;
  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty && !abort;
  assign head_illegal = (h_y == '0) || (h_x == '0) || (h_x[1:0] != 2'b00);
  assign timeout_hit  = (timeout_limit != '0) && (run_cnt == timeout_limit - 1'b1);
  assign busy         = (state != ST_IDLE) || !fifo_empty;

  spu_cmd_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (core_clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (abort),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (q_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      run_cnt             <= '0;
      job_tag             <= '0;
      sm_start            <= 1'b0;
      done_valid          <= 1'b0;
      done_tag            <= '0;
      done_err            <= SM_ERR_OK;
      spu_matrix_y        <= '0;
      spu_matrix_x        <= '0;
      im_base_addr        <= '0;
      om_base_addr        <= '0;
      ifm_addr_align      <= '0;
      ofm_addr_align      <= '0;
      sm_shift_input      <= '0;
      sm_exp_shift_output <= '0;
      sm_shift_output     <= '0;
    end else begin
      sm_start   <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            spu_matrix_y        <= h_y;
            spu_matrix_x        <= h_x;
            im_base_addr        <= h_ib;
            om_base_addr        <= h_ob;
            ifm_addr_align      <= h_ia;
            ofm_addr_align      <= h_oa;
            sm_shift_input      <= h_si;
            sm_exp_shift_output <= h_es;
            sm_shift_output     <= h_so;
            job_tag             <= h_tag;
            if (head_illegal) begin
              state      <= ST_DONE;
              done_valid <= 1'b1;
              done_tag   <= h_tag;
              done_err   <= SM_ERR_ILLEGAL;
            end else begin
              state    <= ST_START;
              sm_start <= 1'b1;
            end
          end
        end
        ST_START: begin
          run_cnt <= '0;
          state   <= ST_RUN;
        end
        // A completion landing in the timeout cycle counts as success.
        ST_RUN: begin
          if (sm_end || timeout_hit) begin
            state      <= ST_DONE;
            done_valid <= 1'b1;
            done_tag   <= job_tag;
            done_err   <= sm_end ? SM_ERR_OK : SM_ERR_TIMEOUT;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= (done_err == SM_ERR_TIMEOUT) ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (abort || sm_end) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_sm_sched.sv
// Randomized self-checking bench for spu_sm_sched; expected cycles, tags and
// error codes are derived from the scheduler's timing rules.
module tb_spu_sm_sched;

  typedef struct {
    logic [11:0] y, x, ib, ob, ia, oa;
    logic [3:0]  si;
    logic [4:0]  es;
    logic [3:0]  so;
    logic [3:0]  tag;
  } desc_t;

  typedef struct {
    int          c;
    logic [3:0]  tag;
    logic [1:0]  err;
  } done_t;

  logic        core_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_matrix_y = '0, cmd_matrix_x = '0, cmd_im_base = '0;
  logic [11:0] cmd_om_base = '0, cmd_ifm_align = '0, cmd_ofm_align = '0;
  logic [3:0]  cmd_shift_input = '0;
  logic [4:0]  cmd_exp_shift_output = '0;
  logic [3:0]  cmd_shift_output = '0;
  logic [3:0]  cmd_tag = '0;
  logic [15:0] timeout_limit = '0;
  logic        abort = 1'b0;
  logic        sm_start;
  logic        sm_end = 1'b0;
  logic [11:0] spu_matrix_y, spu_matrix_x, im_base_addr, om_base_addr;
  logic [11:0] ifm_addr_align, ofm_addr_align;
  logic [3:0]  sm_shift_input;
  logic [4:0]  sm_exp_shift_output;
  logic [3:0]  sm_shift_output;
  logic        done_valid;
  logic [3:0]  done_tag;
  logic [1:0]  done_err;
  logic        busy;
  logic [2:0]  q_count;
  logic [84:0] dut_cfg;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          start_q[$];
  logic [84:0] cfg_q[$];
  done_t       done_q[$];

  spu_sm_sched #(
    .ADDR_WIDTH (12),
    .DEPTH      (4),
    .TAG_WIDTH  (4),
    .TIMEOUT_W  (16)
  ) dut (
    .core_clk             (core_clk),
    .rst                  (rst),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_matrix_y         (cmd_matrix_y),
    .cmd_matrix_x         (cmd_matrix_x),
    .cmd_im_base          (cmd_im_base),
    .cmd_om_base          (cmd_om_base),
    .cmd_ifm_align        (cmd_ifm_align),
    .cmd_ofm_align        (cmd_ofm_align),
    .cmd_shift_input      (cmd_shift_input),
    .cmd_exp_shift_output (cmd_exp_shift_output),
    .cmd_shift_output     (cmd_shift_output),
    .cmd_tag              (cmd_tag),
    .timeout_limit        (timeout_limit),
    .abort                (abort),
    .sm_start             (sm_start),
    .sm_end               (sm_end),
    .spu_matrix_y         (spu_matrix_y),
    .spu_matrix_x         (spu_matrix_x),
    .im_base_addr         (im_base_addr),
    .om_base_addr         (om_base_addr),
    .ifm_addr_align       (ifm_addr_align),
    .ofm_addr_align       (ofm_addr_align),
    .sm_shift_input       (sm_shift_input),
    .sm_exp_shift_output  (sm_exp_shift_output),
    .sm_shift_output      (sm_shift_output),
    .done_valid           (done_valid),
    .done_tag             (done_tag),
    .done_err             (done_err),
    .busy                 (busy),
    .q_count              (q_count)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  assign dut_cfg = {sm_shift_output, sm_exp_shift_output, sm_shift_input, ofm_addr_align,
                    ifm_addr_align, om_base_addr, im_base_addr, spu_matrix_x, spu_matrix_y};

  function automatic logic [84:0] cfg_of(input desc_t d);
    return {d.so, d.es, d.si, d.oa, d.ia, d.ob, d.ib, d.x, d.y};
  endfunction

  function automatic done_t mk_done(input int c, input logic [3:0] tag, input logic [1:0] err);
    done_t r;
    r.c = c; r.tag = tag; r.err = err;
    return r;
  endfunction

  function automatic logic legal(input desc_t d);
    return (d.y != 0) && (d.x != 0) && (d.x % 4 == 0);
  endfunction

  function automatic desc_t rand_desc(input logic [3:0] tag);
    desc_t d;
    d.y   = 12'($urandom_range(1, 4095));
    d.x   = 12'($urandom_range(1, 1023) * 4);
    d.ib  = 12'($urandom);
    d.ob  = 12'($urandom);
    d.ia  = 12'($urandom);
    d.oa  = 12'($urandom);
    d.si  = 4'($urandom);
    d.es  = 5'($urandom);
    d.so  = 4'($urandom);
    d.tag = tag;
    return d;
  endfunction

  // Engine-side observer: logs every start (with config) and every completion.
  always @(negedge core_clk) begin
    if (!rst) begin
      if (sm_start) begin
        start_q.push_back(cyc);
        cfg_q.push_back(dut_cfg);
      end
      if (done_valid) done_q.push_back(mk_done(cyc, done_tag, done_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic clear_log();
    start_q.delete();
    cfg_q.delete();
    done_q.delete();
  endtask

  task automatic push(input desc_t d);
    cmd_matrix_y = d.y;   cmd_matrix_x = d.x;
    cmd_im_base = d.ib;   cmd_om_base = d.ob;
    cmd_ifm_align = d.ia; cmd_ofm_align = d.oa;
    cmd_shift_input = d.si; cmd_exp_shift_output = d.es; cmd_shift_output = d.so;
    cmd_tag = d.tag;
    cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic end_pulse();
    sm_end = 1'b1;
    step(1);
    sm_end = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    vectors++;
    if ({sm_start, done_valid, busy, cmd_ready, q_count, done_tag, done_err} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b, want 0",
               {sm_start, done_valid, busy, cmd_ready, q_count, done_tag, done_err});
    end
    vectors++;
    if (dut_cfg !== 85'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_cfg: got %h, want 0", dut_cfg);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: got %b, want 1", cmd_ready);
    end
    step(1);
  endtask

  task automatic test_single_job();
    desc_t d;
    int c0;
    clear_log();
    d = rand_desc(4'd3);
    d.y = 12'd4;
    d.x = 12'd16;
    c0 = cyc;
    push(d);
    vectors++;
    if (q_count !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL single_qcount: got %0d, want 1", q_count);
    end
    goto(c0 + 2);
    vectors++;
    if (sm_start !== 1'b1 || dut_cfg !== cfg_of(d)) begin
      miscompares++;
      $display("[TB] FAIL single_start: got start=%b cfg=%h, want start=1 cfg=%h",
               sm_start, dut_cfg, cfg_of(d));
    end
    goto(c0 + 52);
    vectors++;
    if (dut_cfg !== cfg_of(d)) begin
      miscompares++;
      $display("[TB] FAIL single_cfg_hold: got %h, want %h", dut_cfg, cfg_of(d));
    end
    end_pulse();
    vectors++;
    if ({done_valid, done_tag, done_err} !== {1'b1, 4'd3, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL single_done: got v=%b tag=%0d err=%0d, want v=1 tag=3 err=0",
               done_valid, done_tag, done_err);
    end
    step(4);
    vectors++;
    if (start_q.size() != 1 || done_q.size() != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_counts: got starts=%0d dones=%0d busy=%b, want 1 1 0",
               start_q.size(), done_q.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    desc_t jobs[5];
    int    n[5];
    int    c0, es;
    clear_log();
    for (int i = 0; i < 5; i++) jobs[i] = rand_desc(4'(i));
    c0 = cyc;
    push(jobs[0]);
    goto(c0 + 3);
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (cmd_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready_%0d: got %b, want 1", i, cmd_ready);
      end
      push(jobs[i]);
    end
    vectors++;
    if ({cmd_ready, q_count} !== {1'b0, 3'd4}) begin
      miscompares++;
      $display("[TB] FAIL b2b_full: got ready=%b count=%0d, want ready=0 count=4", cmd_ready, q_count);
    end
    n[0] = c0 + 10;
    for (int i = 1; i < 5; i++) n[i] = n[i-1] + 3 + $urandom_range(1, 20);
    for (int i = 0; i < 5; i++) begin
      goto(n[i]);
      end_pulse();
      if (i == 0) begin
        goto(n[0] + 3);
        vectors++;
        if ({cmd_ready, q_count} !== {1'b1, 3'd3}) begin
          miscompares++;
          $display("[TB] FAIL b2b_ready_after_pop: got ready=%b count=%0d, want ready=1 count=3",
                   cmd_ready, q_count);
        end
      end
    end
    step(4);
    vectors++;
    if (start_q.size() != 5 || done_q.size() != 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_counts: got starts=%0d dones=%0d, want 5 5", start_q.size(), done_q.size());
    end
    for (int i = 0; i < 5 && i < start_q.size() && i < done_q.size(); i++) begin
      es = (i == 0) ? c0 + 2 : n[i-1] + 3;
      vectors++;
      if (start_q[i] != es || cfg_q[i] !== cfg_of(jobs[i]) || done_q[i].c != n[i] + 1 ||
          done_q[i].tag !== 4'(i) || done_q[i].err !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL b2b_job_%0d: got start=%0d done=%0d tag=%0d err=%0d, want start=%0d done=%0d tag=%0d err=0 (cfg ok=%b)",
                 i, start_q[i], done_q[i].c, done_q[i].tag, done_q[i].err, es, n[i] + 1, i,
                 cfg_q[i] === cfg_of(jobs[i]));
      end
    end
  endtask

  task automatic test_illegal();
    desc_t       a, b;
    int          c0, sa, sb, da, db;
    int          exp_s[$];
    logic [84:0] exp_c[$];
    done_t       exp_d[$];
    clear_log();
    for (int it = 0; it < 4; it++) begin
      a = rand_desc(4'($urandom));
      b = rand_desc(4'($urandom));
      if (it == 0) begin
        a.y = 12'd4;
        a.x = 12'd18;
      end else begin
        a.x = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 2) == 0) a.y = 12'd0;
      end
      da = $urandom_range(1, 15);
      db = $urandom_range(1, 15);
      c0 = cyc;
      push(a);
      push(b);
      if (legal(a)) begin
        sa = c0 + 2;
        exp_s.push_back(sa);
        exp_c.push_back(cfg_of(a));
        goto(sa + da);
        end_pulse();
        exp_d.push_back(mk_done(sa + da + 1, a.tag, 2'd0));
        sb = sa + da + 3;
      end else begin
        exp_d.push_back(mk_done(c0 + 2, a.tag, 2'd1));
        sb = c0 + 4;
      end
      exp_s.push_back(sb);
      exp_c.push_back(cfg_of(b));
      goto(sb + db);
      end_pulse();
      exp_d.push_back(mk_done(sb + db + 1, b.tag, 2'd0));
      step(3);
    end
    vectors++;
    if (start_q.size() != exp_s.size() || done_q.size() != exp_d.size()) begin
      miscompares++;
      $display("[TB] FAIL illegal_counts: got starts=%0d dones=%0d, want %0d %0d",
               start_q.size(), done_q.size(), exp_s.size(), exp_d.size());
    end
    for (int i = 0; i < exp_s.size() && i < start_q.size(); i++) begin
      vectors++;
      if (start_q[i] != exp_s[i] || cfg_q[i] !== exp_c[i]) begin
        miscompares++;
        $display("[TB] FAIL illegal_start_%0d: got cyc=%0d cfg=%h, want cyc=%0d cfg=%h",
                 i, start_q[i], cfg_q[i], exp_s[i], exp_c[i]);
      end
    end
    for (int i = 0; i < exp_d.size() && i < done_q.size(); i++) begin
      vectors++;
      if (done_q[i].c != exp_d[i].c || done_q[i].tag !== exp_d[i].tag || done_q[i].err !== exp_d[i].err) begin
        miscompares++;
        $display("[TB] FAIL illegal_done_%0d: got cyc=%0d tag=%0d err=%0d, want cyc=%0d tag=%0d err=%0d",
                 i, done_q[i].c, done_q[i].tag, done_q[i].err, exp_d[i].c, exp_d[i].tag, exp_d[i].err);
      end
    end
  endtask

  task automatic test_timeout();
    desc_t j1, j2, j3;
    int    lim, c0, s1, d1, m, s2, s3;
    int    exp_s[$];
    done_t exp_d[$];
    clear_log();
    for (int it = 0; it < 2; it++) begin
      lim = (it == 0) ? 10 : $urandom_range(1, 30);
      timeout_limit = 16'(lim);
      j1 = rand_desc(4'($urandom));
      j2 = rand_desc(4'($urandom));
      j3 = rand_desc(4'($urandom));
      c0 = cyc;
      push(j1);
      s1 = c0 + 2;
      d1 = s1 + lim + 1;
      exp_s.push_back(s1);
      exp_d.push_back(mk_done(d1, j1.tag, 2'd2));
      goto(d1 + 2);
      vectors++;
      if ({busy, q_count} !== {1'b1, 3'd0}) begin
        miscompares++;
        $display("[TB] FAIL timeout_drain_busy: got busy=%b count=%0d, want busy=1 count=0", busy, q_count);
      end
      push(j2);
      m = d1 + 20;
      goto(m);
      end_pulse();
      s2 = m + 2;
      exp_s.push_back(s2);
      goto(s2 + lim);
      end_pulse();
      exp_d.push_back(mk_done(s2 + lim + 1, j2.tag, 2'd0));
      goto(s2 + lim + 4);
      s3 = cyc + 2;
      push(j3);
      exp_s.push_back(s3);
      goto(s3 + 1);
      end_pulse();
      exp_d.push_back(mk_done(s3 + 2, j3.tag, 2'd0));
      step(3);
    end
    timeout_limit = '0;
    vectors++;
    if (start_q.size() != exp_s.size() || done_q.size() != exp_d.size()) begin
      miscompares++;
      $display("[TB] FAIL timeout_counts: got starts=%0d dones=%0d, want %0d %0d",
               start_q.size(), done_q.size(), exp_s.size(), exp_d.size());
    end
    for (int i = 0; i < exp_s.size() && i < start_q.size(); i++) begin
      vectors++;
      if (start_q[i] != exp_s[i]) begin
        miscompares++;
        $display("[TB] FAIL timeout_start_%0d: got cyc=%0d, want cyc=%0d", i, start_q[i], exp_s[i]);
      end
    end
    for (int i = 0; i < exp_d.size() && i < done_q.size(); i++) begin
      vectors++;
      if (done_q[i].c != exp_d[i].c || done_q[i].tag !== exp_d[i].tag || done_q[i].err !== exp_d[i].err) begin
        miscompares++;
        $display("[TB] FAIL timeout_done_%0d: got cyc=%0d tag=%0d err=%0d, want cyc=%0d tag=%0d err=%0d",
                 i, done_q[i].c, done_q[i].tag, done_q[i].err, exp_d[i].c, exp_d[i].tag, exp_d[i].err);
      end
    end
  endtask

  task automatic test_abort();
    desc_t a, b, c, x;
    int    c0;
    clear_log();
    a = rand_desc(4'($urandom));
    b = rand_desc(4'($urandom));
    c = rand_desc(4'($urandom));
    x = rand_desc(4'($urandom));
    c0 = cyc;
    push(a);
    push(b);
    push(c);
    goto(c0 + 5);
    vectors++;
    if (q_count !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL abort_pre_count: got %0d, want 2", q_count);
    end
    abort = 1'b1;
    push(x);
    abort = 1'b0;
    vectors++;
    if ({busy, q_count} !== {1'b1, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL abort_flush: got busy=%b count=%0d, want busy=1 count=0", busy, q_count);
    end
    goto(c0 + 10);
    end_pulse();
    vectors++;
    if ({done_valid, done_tag, done_err} !== {1'b1, a.tag, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL abort_running_done: got v=%b tag=%0d err=%0d, want v=1 tag=%0d err=0",
               done_valid, done_tag, done_err, a.tag);
    end
    step(10);
    vectors++;
    if (start_q.size() != 1 || start_q[0] != c0 + 2 || done_q.size() != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_more_jobs: got starts=%0d dones=%0d busy=%b, want 1 1 0",
               start_q.size(), done_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_run();
    desc_t a, e;
    int    c1;
    clear_log();
    a = rand_desc(4'($urandom));
    e = rand_desc(4'($urandom));
    c1 = cyc;
    push(a);
    push(rand_desc(4'($urandom)));
    push(rand_desc(4'($urandom)));
    goto(c1 + 6);
    rst = 1'b1;
    #1;
    vectors++;
    if ({sm_start, done_valid, busy, cmd_ready, q_count, done_tag, done_err} !== 13'd0 || dut_cfg !== 85'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: got outs=%b cfg=%h, want all 0",
               {sm_start, done_valid, busy, cmd_ready, q_count, done_tag, done_err}, dut_cfg);
    end
    step(2);
    vectors++;
    if ({busy, cmd_ready, q_count} !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset_hold: got %b, want 0", {busy, cmd_ready, q_count});
    end
    rst = 1'b0;
    clear_log();
    step(1);
    c1 = cyc;
    push(e);
    goto(c1 + 2);
    vectors++;
    if (sm_start !== 1'b1 || dut_cfg !== cfg_of(e)) begin
      miscompares++;
      $display("[TB] FAIL midrun_restart: got start=%b cfg=%h, want start=1 cfg=%h",
               sm_start, dut_cfg, cfg_of(e));
    end
    goto(c1 + 6);
    end_pulse();
    vectors++;
    if ({done_valid, done_tag, done_err} !== {1'b1, e.tag, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL midrun_done: got v=%b tag=%0d err=%0d, want v=1 tag=%0d err=0",
               done_valid, done_tag, done_err, e.tag);
    end
    step(5);
    vectors++;
    if (start_q.size() != 1 || done_q.size() != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_counts: got starts=%0d dones=%0d busy=%b, want 1 1 0",
               start_q.size(), done_q.size(), busy);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no $finish by 1000000, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
